// File: rtl/shift_deserializer.sv
// Framed serial-to-parallel receiver: assembles NBIT-bit words from a valid-strobed
// bit stream, pulses o_q_vld on completion and o_err on an early start-of-frame.
module shift_deserializer #(
    parameter int unsigned NBIT      = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_s,
    input  logic            i_s_vld,
    input  logic            i_sof,
    output logic [NBIT-1:0] o_q,
    output logic            o_q_vld,
    output logic            o_err,
    output logic            o_busy
);

    localparam int unsigned CNT_W = $clog2(NBIT) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBIT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [NBIT-1:0]   sr, sr_n;
    logic [NBIT-1:0]   q_n;
    logic              q_vld_n;
    logic              err_n;
    logic              busy_n;
    logic [NBIT-1:0]   word_c;

    // Insert one bit at the end that keeps the first-received bit in its final position.
    function automatic logic [NBIT-1:0] shift_in(input logic [NBIT-1:0] cur, input logic b);
        if (MSB_FIRST != 0) begin
            return {cur[NBIT-2:0], b};
        end else begin
            return {b, cur[NBIT-1:1]};
        end
    endfunction

    assign word_c = shift_in(sr, i_s);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sr      <= '0;
            o_q     <= '0;
            o_q_vld <= 1'b0;
            o_err   <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            sr      <= sr_n;
            o_q     <= q_n;
            o_q_vld <= q_vld_n;
            o_err   <= err_n;
            o_busy  <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        q_n     = o_q;
        q_vld_n = 1'b0;
        err_n   = 1'b0;

        case (state)
            IDLE: begin
                // Unframed bits are dropped; only a start-of-frame opens a word.
                if (i_s_vld && i_sof) begin
                    sr_n    = shift_in('0, i_s);
                    cnt_n   = CNT_W'(1);
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (i_s_vld) begin
                    if (i_sof) begin
                        // Early restart: abandon the partial word, this bit starts a new one.
                        err_n = 1'b1;
                        sr_n  = shift_in('0, i_s);
                        cnt_n = CNT_W'(1);
                    end else if (cnt == LAST_BIT) begin
                        sr_n    = word_c;
                        q_n     = word_c;
                        q_vld_n = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        sr_n  = word_c;
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        busy_n = (state_n == SHIFT);
    end

endmodule

// File: tb/tb_shift_deserializer.sv
// Scoreboard bench for shift_deserializer: MSB-first and LSB-first instances share one stimulus.
module tb_shift_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       s, s_vld, sof;
    logic [7:0] q_m, q_l;
    logic       q_vld_m, q_vld_l, err_m, err_l, busy_m, busy_l;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int err_seen_m = 0;
    int err_seen_l = 0;

    logic [7:0] exp_m[$];
    logic [7:0] exp_l[$];
    int         vld_cyc_m[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_deserializer #(.NBIT(8), .MSB_FIRST(1)) dut_m (
        .i_clk(clk), .i_rst(rst), .i_s(s), .i_s_vld(s_vld), .i_sof(sof),
        .o_q(q_m), .o_q_vld(q_vld_m), .o_err(err_m), .o_busy(busy_m)
    );

    shift_deserializer #(.NBIT(8), .MSB_FIRST(0)) dut_l (
        .i_clk(clk), .i_rst(rst), .i_s(s), .i_s_vld(s_vld), .i_sof(sof),
        .o_q(q_l), .o_q_vld(q_vld_l), .o_err(err_l), .o_busy(busy_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: pops expected words whenever a DUT presents one.
    always @(negedge clk) begin
        if (q_vld_m) begin
            vld_cyc_m.push_back(cyc);
            if (exp_m.size() == 0) check("vld_m_unexpected", 32'(q_vld_m), 32'd0);
            else check("word_m", 32'(q_m), 32'(exp_m.pop_front()));
        end
        if (q_vld_l) begin
            if (exp_l.size() == 0) check("vld_l_unexpected", 32'(q_vld_l), 32'd0);
            else check("word_l", 32'(q_l), 32'(exp_l.pop_front()));
        end
        if (err_m) begin
            err_seen_m++;
            check("err_vld_excl_m", 32'(q_vld_m), 32'd0);
        end
        if (err_l) begin
            err_seen_l++;
            check("err_vld_excl_l", 32'(q_vld_l), 32'd0);
        end
    end

    task automatic drive(input logic b, input logic v, input logic f);
        s = b; s_vld = v; sof = f;
        @(posedge clk);
        #1;
    endtask

    // Send the first nbits of seq (seq[7] first), sof on the first bit, optional gap.
    task automatic send(input logic [7:0] seq, input int nbits, input bit push,
                        input logic [7:0] em, input logic [7:0] el,
                        input int gap_after, input int gap_len, output int busy_hi);
        busy_hi = 0;
        if (push) begin
            exp_m.push_back(em);
            exp_l.push_back(el);
        end
        for (int i = 0; i < nbits; i++) begin
            if (i == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    drive(1'b0, 1'b0, 1'b0);
                    busy_hi += int'(busy_m);
                end
            end
            drive(seq[7-i], 1'b1, (i == 0));
            busy_hi += int'(busy_m);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int bh;
        rst = 1'b1; s = 1'b0; s_vld = 1'b0; sof = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q_m", 32'(q_m), 32'd0);
        check("rst_vld_m", 32'(q_vld_m), 32'd0);
        check("rst_err_m", 32'(err_m), 32'd0);
        check("rst_busy_m", 32'(busy_m), 32'd0);
        rst = 1'b0;

        // Basic word, MSB-first A5 (palindromic so LSB-first also A5).
        send(8'hA5, 8, 1'b1, 8'hA5, 8'hA5, -1, 0, bh);
        check("basic_busy_cycles", 32'(bh), 32'd7);
        drive(1'b0, 1'b0, 1'b0);

        // Gap of 3 idle cycles between bits 3 and 4.
        send(8'hA5, 8, 1'b1, 8'hA5, 8'hA5, 3, 3, bh);
        check("gap_busy_cycles", 32'(bh), 32'd10);
        drive(1'b0, 1'b0, 1'b0);

        // Bits 1,0,0,0,0,0,0,0: 0x80 MSB-first, 0x01 LSB-first.
        send(8'h80, 8, 1'b1, 8'h80, 8'h01, -1, 0, bh);
        // Bits 1,1,0,1,0,0,0,0: 0xD0 MSB-first, 0x0B LSB-first.
        send(8'hD0, 8, 1'b1, 8'hD0, 8'h0B, -1, 0, bh);
        drive(1'b0, 1'b0, 1'b0);

        // Unframed bits while idle must be ignored.
        bh = 0;
        for (int i = 0; i < 5; i++) begin
            drive(i[0], 1'b1, 1'b0);
            bh += int'(busy_m) + int'(busy_l);
        end
        check("unframed_busy", 32'(bh), 32'd0);
        check("unframed_q_m", 32'(q_m), 32'hD0);
        check("unframed_q_l", 32'(q_l), 32'h0B);
        drive(1'b0, 1'b0, 1'b0);

        // Early restart after 4 bits, then full 0x3C.
        send(8'hF0, 4, 1'b0, 8'h00, 8'h00, -1, 0, bh);
        check("restart_busy", 32'(busy_m), 32'd1);
        check("restart_q_hold_m", 32'(q_m), 32'hD0);
        drive(1'b0, 1'b1, 1'b1);
        check("restart_q_hold_after_sof", 32'(q_m), 32'hD0);
        check("restart_err_m", 32'(err_m), 32'd1);
        check("restart_busy_after_sof", 32'(busy_m), 32'd1);
        send(8'h3C, 8, 1'b1, 8'h3C, 8'h3C, -1, 0, bh);
        drive(1'b0, 1'b0, 1'b0);
        check("restart_err_count_m", 32'(err_seen_m), 32'd2);
        check("restart_err_count_l", 32'(err_seen_l), 32'd2);
        check("restart_q_l", 32'(q_l), 32'h3C);

        // Back-to-back words, 16 consecutive valid bits.
        vld_cyc_m.delete();
        send(8'h3C, 8, 1'b1, 8'h3C, 8'h3C, -1, 0, bh);
        send(8'hC3, 8, 1'b1, 8'hC3, 8'hC3, -1, 0, bh);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("b2b_vld_count", 32'(vld_cyc_m.size()), 32'd2);
        if (vld_cyc_m.size() == 2)
            check("b2b_vld_spacing", 32'(vld_cyc_m[1] - vld_cyc_m[0]), 32'd8);
        check("b2b_no_err", 32'(err_seen_m), 32'd2);

        // Reset asserted between edges after 5 bits of a word.
        send(8'h5A, 5, 1'b0, 8'h00, 8'h00, -1, 0, bh);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_q_m", 32'(q_m), 32'd0);
        check("midrst_q_l", 32'(q_l), 32'd0);
        check("midrst_busy", 32'({busy_m, busy_l}), 32'd0);
        check("midrst_vld_err", 32'({q_vld_m, q_vld_l, err_m, err_l}), 32'd0);
        s_vld = 1'b0; sof = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'hFF, 8, 1'b1, 8'hFF, 8'hFF, -1, 0, bh);
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        check("final_err_count", 32'(err_seen_m + err_seen_l), 32'd4);
        check("final_q_m", 32'(q_m), 32'hFF);
        check("pending_m", 32'(exp_m.size()), 32'd0);
        check("pending_l", 32'(exp_l.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
